host_link_decoder: RTL and testbench
====================================

HOST_LINK_DECODER -- requirements
Module: host_link_decoder

Interface
REQ-001 The block SHALL have parameter OUTPUT_WIDTH, default 16, write data width (8..16 legal).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit.
REQ-003 The block SHALL have parameter TIMEOUT_CLKS, default 20*868, maximum idle gap between bytes inside a frame.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rxd  input  1  asynchronous UART serial input from host, idle high.
REQ-007 wr_enable  output  1  one-cycle write strobe to sample memory.
REQ-008 wr_addr  output  12  write address, valid while wr_enable is high.
REQ-009 wr_data  output  OUTPUT_WIDTH  write data, valid while wr_enable is high.
REQ-010 step  output  12  registered playback step.
REQ-011 range  output  12  registered playback range.
REQ-012 frame_err  output  1  one-cycle pulse on any rejected byte or frame.
REQ-013 cmd_done  output  1  one-cycle pulse when a frame is executed.

Function
REQ-014 rxd SHALL pass through a 2-flop synchroniser before use.
REQ-015 UART receive SHALL be 8N1, LSB first; a start edge is confirmed at CLKS_PER_BIT/2, and each subsequent bit is sampled every CLKS_PER_BIT cycles from there.
REQ-016 A start bit low at its mid-sample SHALL proceed; if high, the receiver SHALL return to idle silently.
REQ-017 A stop bit sampled low SHALL discard the byte, pulse frame_err, and return the parser to IDLE.
REQ-018 Each accepted byte SHALL produce a one-cycle byte_valid to the parser, on the cycle after the stop-bit sample.
REQ-019 Frame format: 0xA5 sync, opcode, 4 payload bytes P0..P3, checksum = opcode XOR P0 XOR P1 XOR P2 XOR P3.
REQ-020 Parser states: IDLE, OPCODE, PAYLOAD (2-bit byte counter), CHECK, EXEC.
REQ-021 In IDLE, 0xA5 SHALL move to OPCODE; any other byte SHALL be dropped with no frame_err.
REQ-022 In OPCODE, 0x01, 0x02 or 0x03 SHALL be latched and move to PAYLOAD; any other value SHALL pulse frame_err and return to IDLE.
REQ-023 In PAYLOAD, bytes SHALL be stored to P0..P3, moving to CHECK after P3.
REQ-024 A checksum match in CHECK SHALL move to EXEC; a mismatch SHALL pulse frame_err, return to IDLE and leave all outputs unchanged.
REQ-025 EXEC SHALL last exactly one cycle, pulse cmd_done, and return to IDLE.
REQ-026 Opcode 0x01 WRITE SHALL set wr_addr={P0[3:0],P1}, set wr_data={P2,P3}[OUTPUT_WIDTH-1:0] and assert wr_enable in EXEC; P0[7:4] SHALL be ignored.
REQ-027 Opcode 0x02 SET_STEP SHALL load step={P0[3:0],P1} in EXEC; P2 and P3 SHALL be ignored.
REQ-028 Opcode 0x03 SET_RANGE SHALL load range={P0[3:0],P1} in EXEC; P2 and P3 SHALL be ignored.
REQ-029 Latency SHALL be exactly 1 clk from the checksum byte_valid to wr_enable/cmd_done, and to the cycle step/range show the new value.
REQ-030 In any non-IDLE state, TIMEOUT_CLKS cycles without byte_valid SHALL pulse frame_err and return to IDLE; the gap counter SHALL restart on each byte_valid.
REQ-031 wr_addr and wr_data SHALL hold their last values when wr_enable is low.
REQ-032 0xA5 received inside a frame SHALL be treated as ordinary data.
REQ-033 frame_err and cmd_done SHALL never be asserted in the same cycle.

Reset
REQ-034 Reset SHALL force IDLE and receiver idle, and clear the byte and gap counters.
REQ-035 Reset SHALL set wr_enable=0, wr_addr=0, wr_data=0, step=12'd1, range=12'hFFF, frame_err=0, cmd_done=0.
REQ-036 Reset mid-byte or mid-frame SHALL discard the partial data, with no write and no frame_err.

Structure
REQ-037 A shared package SHALL hold the sync byte 0xA5, the opcode constants 0x01/0x02/0x03, the parser state encoding, and the reset values of step/range.
REQ-038 The UART bit receiver SHALL be a separate sub-module uart_rx (synchroniser, bit timing, byte_valid, stop_err); the parser SHALL stay in host_link_decoder.

Verification (bench uses CLKS_PER_BIT=8, TIMEOUT_CLKS=200)
REQ-039 Send A5 01 03 45 BE EF 16 -> one wr_enable with wr_addr=0x345, wr_data=0xBEEF, cmd_done same cycle, 1 clk after the last byte_valid.
REQ-040 Send A5 02 00 04 00 00 06 -> step=0x004; then send A5 03 07 FF 00 00 FB -> range=0x7FF; no wr_enable.
REQ-041 Send A5 01 03 45 BE EF 00 (bad checksum) -> frame_err pulse, no wr_enable; a following valid frame executes normally.
REQ-042 Send A5 07 -> frame_err; send A5 01 00 then idle 250 cycles -> frame_err from timeout, parser returns to IDLE.
REQ-043 Send a byte with stop bit forced low during the payload -> frame_err, frame aborted; garbage 0x11 0x22 in IDLE -> no frame_err.
REQ-044 Assert reset after the P1 byte of a WRITE frame -> outputs at reset values (step=1, range=0xFFF), no write; the next full frame succeeds.

Source files
------------

// File: rtl/host_link_decoder_pkg.sv
// Shared constants and state encodings for the host link decoder.
// Holds the sync byte, opcodes, parser/receiver states and step/range reset values.
package host_link_decoder_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam logic [7:0] OP_WRITE  = 8'h01;
   localparam logic [7:0] OP_STEP   = 8'h02;
   localparam logic [7:0] OP_RANGE  = 8'h03;

   localparam logic [11:0] STEP_RESET  = 12'd1;
   localparam logic [11:0] RANGE_RESET = 12'hFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPCODE,
      ST_PAYLOAD,
      ST_CHECK,
      ST_EXEC
   } parser_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/host_link_decoder_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling,
// one-cycle byte_valid or stop_err pulse on the cycle after the stop-bit sample.
module uart_rx
   import host_link_decoder_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic       byte_valid,
   output logic [7:0] data,
   output logic       stop_err
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   logic          sync1, sync2;
   rx_state_t     state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_nx;
   logic [7:0]    shreg, sh_nx;
   logic          valid_nx, err_nx;

   assign data = shreg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         sync1      <= rxd;
         sync2      <= sync1;
         state      <= state_nx;
         cnt        <= cnt_nx;
         bit_idx    <= bit_nx;
         shreg      <= sh_nx;
         byte_valid <= valid_nx;
         stop_err   <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      bit_nx   = bit_idx;
      sh_nx    = shreg;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      case (state)
         RX_IDLE: begin
            cnt_nx = '0;
            if (!sync2) state_nx = RX_START;
         end
         RX_START: begin
            // a start that has gone high again by mid-bit is treated as a glitch
            if (cnt == HALF_LAST) begin
               cnt_nx   = '0;
               bit_nx   = '0;
               state_nx = sync2 ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_nx = '0;
               sh_nx  = {sync2, shreg[7:1]};
               bit_nx = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nx = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_nx   = '0;
               state_nx = RX_IDLE;
               valid_nx = sync2;
               err_nx   = !sync2;
            end
         end
         default: state_nx = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/host_link_decoder.sv
// Host command link: UART bytes framed as A5/opcode/P0..P3/checksum,
// executed as sample-memory writes or step/range register loads.
module host_link_decoder
   import host_link_decoder_pkg::*;
#(
   parameter int OUTPUT_WIDTH = 16,
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_CLKS = 20 * 868
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rxd,
   output logic                    wr_enable,
   output logic [11:0]             wr_addr,
   output logic [OUTPUT_WIDTH-1:0] wr_data,
   output logic [11:0]             step,
   output logic [11:0]             range,
   output logic                    frame_err,
   output logic                    cmd_done
);

   localparam int GW = $clog2(TIMEOUT_CLKS + 1);

   logic          byte_valid, stop_err;
   logic [7:0]    rx_byte;
   parser_state_t state, state_nx;
   logic [1:0]    pay_cnt;
   logic [7:0]    opcode;
   logic [3:0][7:0] pay;
   logic [GW-1:0] gap;
   logic          timeout, cks_ok, err_nx, exec_go;
   logic [15:0]   wd;
   logic [11:0]   arg;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rxd        (rxd),
      .byte_valid (byte_valid),
      .data       (rx_byte),
      .stop_err   (stop_err)
   );

   assign timeout = (state != ST_IDLE) && !byte_valid && (gap == GW'(TIMEOUT_CLKS - 1));
   assign cks_ok  = (rx_byte == (opcode ^ pay[0] ^ pay[1] ^ pay[2] ^ pay[3]));
   assign wd      = {pay[2], pay[3]};
   assign arg     = {pay[0][3:0], pay[1]};

   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      exec_go  = 1'b0;
      if (stop_err || timeout) begin
         state_nx = ST_IDLE;
         err_nx   = 1'b1;
      end else begin
         case (state)
            ST_IDLE:
               if (byte_valid && rx_byte == SYNC_BYTE) state_nx = ST_OPCODE;
            ST_OPCODE:
               if (byte_valid) begin
                  if (rx_byte inside {OP_WRITE, OP_STEP, OP_RANGE}) begin
                     state_nx = ST_PAYLOAD;
                  end else begin
                     state_nx = ST_IDLE;
                     err_nx   = 1'b1;
                  end
               end
            ST_PAYLOAD:
               if (byte_valid && pay_cnt == 2'd3) state_nx = ST_CHECK;
            ST_CHECK:
               if (byte_valid) begin
                  if (cks_ok) begin
                     state_nx = ST_EXEC;
                     exec_go  = 1'b1;
                  end else begin
                     state_nx = ST_IDLE;
                     err_nx   = 1'b1;
                  end
               end
            ST_EXEC:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
         endcase
      end
   end

   // Outputs are loaded on the CHECK->EXEC edge so they appear in the EXEC cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         pay_cnt   <= '0;
         opcode    <= '0;
         pay       <= '0;
         gap       <= '0;
         wr_enable <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         step      <= STEP_RESET;
         range     <= RANGE_RESET;
         frame_err <= 1'b0;
         cmd_done  <= 1'b0;
      end else begin
         state     <= state_nx;
         frame_err <= err_nx;
         cmd_done  <= exec_go;
         wr_enable <= exec_go && (opcode == OP_WRITE);
         gap       <= (state_nx == ST_IDLE || byte_valid) ? '0 : gap + 1'b1;
         if (byte_valid) begin
            if (state == ST_OPCODE) begin
               opcode  <= rx_byte;
               pay_cnt <= '0;
            end else if (state == ST_PAYLOAD) begin
               pay[pay_cnt] <= rx_byte;
               pay_cnt      <= pay_cnt + 2'd1;
            end
         end
         if (exec_go) begin
            case (opcode)
               OP_WRITE: begin
                  wr_addr <= arg;
                  wr_data <= wd[OUTPUT_WIDTH-1:0];
               end
               OP_STEP:  step  <= arg;
               OP_RANGE: range <= arg;
               default:  ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_host_link_decoder.sv
// Randomized scoreboard bench for host_link_decoder: a frame-level queue model
// predicts each cmd_done/frame_err event, and a monitor compares as they appear.
module tb_host_link_decoder;

   localparam int CPB = 8;
   localparam int TMO = 200;
   localparam int OW  = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          rxd;
   logic          wr_enable, frame_err, cmd_done;
   logic [11:0]   wr_addr, step, rng;
   logic [OW-1:0] wr_data;

   always #5 clk = ~clk;

   host_link_decoder #(.OUTPUT_WIDTH(OW), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .wr_enable (wr_enable),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .step      (step),
      .range     (rng),
      .frame_err (frame_err),
      .cmd_done  (cmd_done)
   );

   typedef struct {
      bit          err;
      bit          wr;
      logic [11:0] addr;
      logic [15:0] data;
      logic [11:0] step;
      logic [11:0] rng;
   } ev_t;

   ev_t         exp_q[$];
   logic [7:0]  frm[$];
   logic [11:0] m_step = 12'd1;
   logic [11:0] m_rng  = 12'hFFF;
   int          vectors = 0;
   int          miscompares = 0;
   longint      cyc = 0;
   longint      last_bv = 0;

   function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push_ev(input bit err, input bit wr, input logic [11:0] a, input logic [15:0] d);
      ev_t e;
      e.err  = err;
      e.wr   = wr;
      e.addr = a;
      e.data = d;
      e.step = m_step;
      e.rng  = m_rng;
      exp_q.push_back(e);
   endfunction

   // Frame-level model: collect bytes from a sync byte until the frame is complete or rejected.
   function automatic void model_byte(input logic [7:0] b);
      logic [7:0]  x;
      logic [11:0] a;
      if (frm.size() == 0 && b != 8'hA5) return;
      frm.push_back(b);
      if (frm.size() == 2 && !(b inside {8'h01, 8'h02, 8'h03})) begin
         push_ev(1'b1, 1'b0, '0, '0);
         frm.delete();
      end else if (frm.size() == 7) begin
         x = frm[1] ^ frm[2] ^ frm[3] ^ frm[4] ^ frm[5];
         a = {frm[2][3:0], frm[3]};
         if (x != frm[6]) push_ev(1'b1, 1'b0, '0, '0);
         else if (frm[1] == 8'h01) push_ev(1'b0, 1'b1, a, {frm[4], frm[5]});
         else begin
            if (frm[1] == 8'h02) m_step = a;
            else m_rng = a;
            push_ev(1'b0, 1'b0, '0, '0);
         end
         frm.delete();
      end
   endfunction

   function automatic void model_abort(input bit err);
      if (err) push_ev(1'b1, 1'b0, '0, '0);
      frm.delete();
   endfunction

   function automatic logic [7:0] cks(input logic [7:0] op, p0, p1, p2, p3);
      return op ^ p0 ^ p1 ^ p2 ^ p3;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      model_byte(b);
      send_byte(b, 1'b1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
   endtask

   task automatic send_bad_stop(input logic [7:0] b);
      model_abort(1'b1);
      send_byte(b, 1'b0);
      repeat (16) @(negedge clk);
   endtask

   task automatic idle_timeout();
      if (frm.size() != 0) model_abort(1'b1);
      repeat (250) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] op, p0, p1, p2, p3, ck);
      send(8'hA5); send(op); send(p0); send(p1); send(p2); send(p3); send(ck);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      frm.delete();
      m_step = 12'd1;
      m_rng  = 12'hFFF;
      repeat (3) @(negedge clk);
      cmp("rst_wr_enable", wr_enable, 0);
      cmp("rst_wr_addr",   wr_addr,   0);
      cmp("rst_wr_data",   wr_data,   0);
      cmp("rst_step",      step,      12'd1);
      cmp("rst_range",     rng,       12'hFFF);
      cmp("rst_frame_err", frame_err, 0);
      cmp("rst_cmd_done",  cmd_done,  0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   always @(negedge clk) begin
      ev_t e;
      cyc++;
      if (!reset && (frame_err || cmd_done || wr_enable)) begin
         cmp("err_done_exclusive", frame_err & cmd_done, 0);
         if (wr_enable) cmp("wr_needs_done", cmd_done, 1);
         if (frame_err || cmd_done) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_event: frame_err=%0b cmd_done=%0b, required no event", frame_err, cmd_done);
            end else begin
               e = exp_q.pop_front();
               cmp("event_is_err", frame_err, e.err);
               if (cmd_done && !e.err) begin
                  cmp("latency",   32'(cyc - last_bv), 1);
                  cmp("wr_enable", wr_enable, e.wr);
                  if (e.wr) begin
                     cmp("wr_addr", wr_addr, e.addr);
                     cmp("wr_data", wr_data, e.data);
                  end
                  cmp("step",  step, e.step);
                  cmp("range", rng,  e.rng);
               end
            end
         end
      end
      if (dut.u_rx.byte_valid) last_bv = cyc;
   end

   initial begin
      #900us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] op, ck, b;
      logic [7:0] p[4];
      int         k, n;
      rxd   = 1'b1;
      reset = 1'b1;
      do_reset();

      // directed frames
      send_frame(8'h01, 8'h03, 8'h45, 8'hBE, 8'hEF, 8'h16);
      drain();
      send_frame(8'h02, 8'h00, 8'h04, 8'h00, 8'h00, 8'h06);
      send_frame(8'h03, 8'h07, 8'hFF, 8'h00, 8'h00, 8'hFB);
      drain();
      send_frame(8'h01, 8'h03, 8'h45, 8'hBE, 8'hEF, 8'h00);
      send_frame(8'h01, 8'hF1, 8'h23, 8'h12, 8'h34, cks(8'h01, 8'hF1, 8'h23, 8'h12, 8'h34));
      drain();
      send(8'hA5); send(8'h07);
      send(8'hA5); send(8'h01); send(8'h00);
      idle_timeout();
      drain();
      send(8'hA5); send(8'h01); send(8'h03);
      send_bad_stop(8'h45);
      send(8'h11); send(8'h22);
      drain();
      send(8'hA5); send(8'h01); send(8'h03); send(8'h45);
      repeat (6) @(negedge clk);
      do_reset();
      send_frame(8'h01, 8'h0A, 8'hBC, 8'hA5, 8'h5A, cks(8'h01, 8'h0A, 8'hBC, 8'hA5, 8'h5A));
      drain();

      // randomized scenarios
      for (int it = 0; it < 40; it++) begin
         k  = $urandom_range(0, 8);
         op = 8'($urandom_range(1, 3));
         for (int j = 0; j < 4; j++) p[j] = 8'($urandom);
         ck = cks(op, p[0], p[1], p[2], p[3]);
         case (k)
            0, 1, 2: send_frame(op, p[0], p[1], p[2], p[3], ck);
            3: send_frame(op, p[0], p[1], p[2], p[3], ck ^ 8'($urandom_range(1, 255)));
            4: begin
               b = 8'($urandom_range(4, 255));
               send(8'hA5); send(b);
            end
            5: begin
               b = 8'($urandom);
               if (b == 8'hA5) b = 8'h5A;
               send(b);
            end
            6: begin
               n = $urandom_range(0, 3);
               send(8'hA5); send(op);
               for (int j = 0; j < n; j++) send(p[j]);
               send_bad_stop(p[3]);
            end
            7: begin
               n = $urandom_range(0, 5);
               send(8'hA5);
               for (int j = 0; j < n; j++) send(8'($urandom));
               idle_timeout();
            end
            default: begin
               drain();
               n = $urandom_range(0, 4);
               send(8'hA5); send(op);
               for (int j = 0; j < n; j++) send(p[j]);
               repeat (6) @(negedge clk);
               do_reset();
            end
         endcase
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
